inst_cache: RTL and testbench
=============================

# inst_cache

Direct-mapped instruction cache between the Fetcher and the MemoryController's instruction port. Hits are answered in one cycle without touching RAM. Misses are served by sequencing word-sized instruction requests to the MemoryController to fill a whole line, then answering the Fetcher. It also owns the rollback behaviour of the fetch path, so that a flushed fetch never produces a stale response.

## Interface
Parameters:
- INDEX_BITS, 5, log2 of line count (32 lines)
- OFFSET_BITS, 2, log2 of words per line (4 words = 16 bytes)

Ports (one clock `clk`; reset `rst` is asynchronous and active-low):
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- rob_rollback_in  in  1  pipeline flush
- fet_request_in  in  1  one-cycle fetch request pulse
- fet_address_in  in  32  fetch byte address; bits [1:0] ignored
- fet_ready_out  out  1  one-cycle response pulse
- fet_instruction_out  out  32  instruction, valid with fet_ready_out
- mc_request_out  out  1  one-cycle word-read request pulse to MemoryController
- mc_address_out  out  32  word-aligned read address
- mc_ready_in  in  1  one-cycle completion pulse from MemoryController
- mc_instruction_in  in  32  read data, valid with mc_ready_in

## Operation
- Address split: offset = addr[OFFSET_BITS+1:2]; index = next INDEX_BITS bits; tag = remaining upper bits (TAG_BITS = 30 − INDEX_BITS − OFFSET_BITS).
- Storage: valid[2^INDEX_BITS], tag[2^INDEX_BITS], data[2^INDEX_BITS][2^OFFSET_BITS] words.
- FSM states: IDLE, FILL, RESPOND.
- IDLE, fet_request_in=1, hit (valid and tag match, compared combinationally against fet_address_in): return data[index][offset] with fet_ready_out; stay in IDLE.
- IDLE, fet_request_in=1, miss:
  - latch the address;
  - clear valid[index];
  - set word counter to 0;
  - go to FILL and issue mc_request_out for the line base (offset 0).
- FILL, each mc_ready_in:
  - write mc_instruction_in to data[index][counter];
  - if counter is the last word: set valid and tag, go to RESPOND;
  - else increment counter and issue the next request at line base + 4·counter.
- RESPOND: pulse fet_ready_out with the latched word from the freshly filled line; return to IDLE.
- At most one MC request outstanding. No new request is issued before the prior mc_ready_in.
- fet_request_in outside IDLE is ignored (protocol violation; the bench flags it).
- Rollback:
  - In any state: go to IDLE; no fet_ready_out pulse; no further mc_request_out.
  - An mc_ready_in arriving in the rollback cycle or later, before a new fill starts, is discarded.
  - The partially filled line stays invalid.
- Rollback and fet_request_in in the same cycle: rollback wins, request dropped.
- Priority each cycle: reset > rollback > FSM.

## Timing
- Reset values: fet_ready_out=0, fet_instruction_out=0, mc_request_out=0, mc_address_out=0, all valid=0, state=IDLE, counter=0. The reset is async, so outputs clear immediately, including mid-fill.
- Hit latency: request sampled at edge T → fet_ready_out high during cycle T+1 (registered).
- Miss: first mc_request_out high during cycle T+1.
  - Each subsequent request is issued the cycle after the previous mc_ready_in.
  - fet_ready_out comes one cycle after the last mc_ready_in (the RESPOND cycle).
- All pulse outputs are high for exactly one cycle.
- The counter wraps only via the explicit reset to 0 on a new fill.

## Structure
- Shared header: `WORD_RANGE`, `TRUE`/`FALSE`, `ZERO_WORD`. Add cache geometry defaults and the state encodings (IDLE/FILL/RESPOND) as named constants there.
- One sub-module, `inst_cache_store`, holds the valid/tag/data arrays:
  - one combinational read port;
  - one word-write port;
  - one line-tag/valid set-clear port;
  - asynchronous clear of valid.
- The FSM, counter and handshake logic stay in `inst_cache`.

## Test plan
- Cold miss: fetch 0x0000_1004 → mc_request_out addresses 0x1000, 0x1004, 0x1008, 0x100C in order; fet_ready_out with the word from 0x1004 one cycle after the 4th mc_ready_in.
- Hit: after the fill above, fetch 0x0000_1008 → fet_ready_out next cycle with the 0x1008 word; mc_request_out never asserted.
- Conflict eviction: fill 0x1000, then fetch 0x1200 (same index, different tag) → full 4-word refill. A later fetch of 0x1000 misses again.
- Rollback mid-fill: rollback after the 2nd mc_ready_in → no fet_ready_out, no further requests; a late mc_ready_in is ignored. Refetching 0x1000 gives a full 4-request miss.
- Same-cycle rollback and fetch: no mc_request_out, no fet_ready_out, state stays IDLE.
- Async reset mid-fill: drop rst low between clock edges → all outputs 0 before the next edge. After release, fetching the previously valid line misses.

Source files
------------

// File: rtl/inst_cache_pkg.sv
// inst_cache_pkg
//   Shared definitions for the instruction cache: word type, boolean
//   constants, default cache geometry and FSM state encodings.
package inst_cache_pkg;

   // Word range: one 32-bit instruction / address word.
   localparam int WORD_W = 32;
   typedef logic [WORD_W-1:0] word_t;

   localparam logic  TRUE      = 1'b1;
   localparam logic  FALSE     = 1'b0;
   localparam word_t ZERO_WORD = '0;

   // Default geometry: 32 lines of 4 words (16 bytes).
   localparam int DEF_INDEX_BITS  = 5;
   localparam int DEF_OFFSET_BITS = 2;

   // Word-address bits left over for the tag once index and offset are taken.
   function automatic int tag_bits(input int index_bits, input int offset_bits);
      return 30 - index_bits - offset_bits;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FILL    = 2'd1,
      ST_RESPOND = 2'd2
   } state_e;

endpackage

// File: rtl/inst_cache_store.sv
// inst_cache_store
//   Valid / tag / data storage for the direct-mapped instruction cache.
//   Ports:
//     clk, rst          clock, asynchronous active-low reset (clears valid)
//     rd_*              combinational read of valid, tag and one data word
//     wr_*              single word write into a line
//     line_*            set (valid=1, tag written) or clear a line's valid bit
module inst_cache_store
   import inst_cache_pkg::*;
#(
   parameter int INDEX_BITS  = DEF_INDEX_BITS,
   parameter int OFFSET_BITS = DEF_OFFSET_BITS,
   parameter int TAG_BITS    = tag_bits(INDEX_BITS, OFFSET_BITS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [INDEX_BITS-1:0]  rd_index,
   input  logic [OFFSET_BITS-1:0] rd_offset,
   output logic                   rd_valid,
   output logic [TAG_BITS-1:0]    rd_tag,
   output word_t                  rd_data,
   input  logic                   wr_en,
   input  logic [INDEX_BITS-1:0]  wr_index,
   input  logic [OFFSET_BITS-1:0] wr_offset,
   input  word_t                  wr_data,
   input  logic                   line_en,
   input  logic [INDEX_BITS-1:0]  line_index,
   input  logic                   line_valid,
   input  logic [TAG_BITS-1:0]    line_tag
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int WORDS = 1 << OFFSET_BITS;

   logic [LINES-1:0]    valid_q, valid_d;
   logic [TAG_BITS-1:0] tag_mem  [LINES];
   word_t               data_mem [LINES*WORDS];

   always_comb begin
      valid_d = valid_q;
      if (line_en) begin
         valid_d[line_index] = line_valid;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Tag is only meaningful while valid, so it is written on set only.
   always_ff @(posedge clk) begin
      if (line_en && line_valid) begin
         tag_mem[line_index] <= line_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_mem[{wr_index, wr_offset}] <= wr_data;
      end
   end

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_data  = data_mem[{rd_index, rd_offset}];

endmodule

// File: rtl/inst_cache.sv
// inst_cache
//   Direct-mapped instruction cache between the fetcher and the memory
//   controller's instruction port. Hits answer one cycle after the request;
//   misses fill the whole line word by word, then answer. A rollback returns
//   to idle without answering and leaves any partially filled line invalid.
//   Ports:
//     clk, rst                 clock, asynchronous active-low reset
//     rob_rollback_in          pipeline flush (highest priority after reset)
//     fet_request_in/address   one-cycle fetch request and byte address
//     fet_ready_out/instr      one-cycle response pulse and instruction
//     mc_request_out/address   one-cycle word read request to memory
//     mc_ready_in/instruction  one-cycle read completion and data
module inst_cache
   import inst_cache_pkg::*;
#(
   parameter int INDEX_BITS  = DEF_INDEX_BITS,
   parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  rob_rollback_in,
   input  logic  fet_request_in,
   input  word_t fet_address_in,
   output logic  fet_ready_out,
   output word_t fet_instruction_out,
   output logic  mc_request_out,
   output word_t mc_address_out,
   input  logic  mc_ready_in,
   input  word_t mc_instruction_in
);

   localparam int TAG_BITS = tag_bits(INDEX_BITS, OFFSET_BITS);
   localparam logic [OFFSET_BITS-1:0] LAST_WORD = '1;

   state_e                 state_q, state_d;
   logic [29:0]            addr_q, addr_d;      // latched word address of the miss
   logic [OFFSET_BITS-1:0] count_q, count_d;
   logic                   fet_ready_q, fet_ready_d;
   word_t                  fet_instr_q, fet_instr_d;
   logic                   mc_req_q, mc_req_d;
   word_t                  mc_addr_q, mc_addr_d;

   // Byte-select bits of the fetch address carry no information.
   logic unused_byte_bits;
   assign unused_byte_bits = &{1'b0, fet_address_in[1:0]};

   // The single read port looks at the incoming fetch while idle and at the
   // latched miss address otherwise; fill writes and line updates share it.
   logic [29:0]            rd_waddr;
   logic [OFFSET_BITS-1:0] rd_offset;
   logic [INDEX_BITS-1:0]  rd_index;
   logic [TAG_BITS-1:0]    rd_tag_field;
   logic                   st_valid;
   logic [TAG_BITS-1:0]    st_tag;
   word_t                  st_data;
   logic                   hit;
   logic                   wr_en, line_en, line_valid;

   assign rd_waddr     = (state_q == ST_IDLE) ? fet_address_in[31:2] : addr_q;
   assign rd_offset    = rd_waddr[0 +: OFFSET_BITS];
   assign rd_index     = rd_waddr[OFFSET_BITS +: INDEX_BITS];
   assign rd_tag_field = rd_waddr[OFFSET_BITS+INDEX_BITS +: TAG_BITS];
   assign hit          = st_valid && (st_tag == rd_tag_field);

   inst_cache_store #(
      .INDEX_BITS  (INDEX_BITS),
      .OFFSET_BITS (OFFSET_BITS),
      .TAG_BITS    (TAG_BITS)
   ) u_store (
      .clk        (clk),
      .rst        (rst),
      .rd_index   (rd_index),
      .rd_offset  (rd_offset),
      .rd_valid   (st_valid),
      .rd_tag     (st_tag),
      .rd_data    (st_data),
      .wr_en      (wr_en),
      .wr_index   (rd_index),
      .wr_offset  (count_q),
      .wr_data    (mc_instruction_in),
      .line_en    (line_en),
      .line_index (rd_index),
      .line_valid (line_valid),
      .line_tag   (rd_tag_field)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      count_d     = count_q;
      fet_ready_d = FALSE;
      fet_instr_d = fet_instr_q;
      mc_req_d    = FALSE;
      mc_addr_d   = mc_addr_q;
      wr_en       = FALSE;
      line_en     = FALSE;
      line_valid  = FALSE;

      if (rob_rollback_in) begin
         // Drop everything; a late mc_ready_in is ignored in idle.
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (fet_request_in) begin
                  if (hit) begin
                     fet_ready_d = TRUE;
                     fet_instr_d = st_data;
                  end else begin
                     addr_d    = rd_waddr;
                     count_d   = '0;
                     line_en   = TRUE;     // invalidate before refilling
                     state_d   = ST_FILL;
                     mc_req_d  = TRUE;
                     mc_addr_d = {rd_waddr[29:OFFSET_BITS], {OFFSET_BITS{1'b0}}, 2'b00};
                  end
               end
            end
            ST_FILL: begin
               if (mc_ready_in) begin
                  wr_en = TRUE;
                  if (count_q == LAST_WORD) begin
                     line_en     = TRUE;
                     line_valid  = TRUE;
                     state_d     = ST_RESPOND;
                     fet_ready_d = TRUE;
                     // The word arriving now is not in the array until the edge.
                     fet_instr_d = (rd_offset == count_q) ? mc_instruction_in : st_data;
                  end else begin
                     count_d   = count_q + 1'b1;
                     mc_req_d  = TRUE;
                     mc_addr_d = {rd_waddr[29:OFFSET_BITS], count_d, 2'b00};
                  end
               end
            end
            ST_RESPOND: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         count_q     <= '0;
         fet_ready_q <= FALSE;
         fet_instr_q <= ZERO_WORD;
         mc_req_q    <= FALSE;
         mc_addr_q   <= ZERO_WORD;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
         fet_ready_q <= fet_ready_d;
         fet_instr_q <= fet_instr_d;
         mc_req_q    <= mc_req_d;
         mc_addr_q   <= mc_addr_d;
      end
   end

   assign fet_ready_out       = fet_ready_q;
   assign fet_instruction_out = fet_instr_q;
   assign mc_request_out      = mc_req_q;
   assign mc_address_out      = mc_addr_q;

endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache
//   Self-checking bench for inst_cache: a memory responder with random
//   latency, a table of directed fetches, hand-written rollback / reset
//   sequences and random fetches checked against a line-level cache model.
module tb_inst_cache;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rob_rollback_in = 1'b0;
   logic        fet_request_in = 1'b0;
   logic [31:0] fet_address_in = '0;
   logic        fet_ready_out;
   logic [31:0] fet_instruction_out;
   logic        mc_request_out;
   logic [31:0] mc_address_out;
   logic        mc_ready_in = 1'b0;
   logic [31:0] mc_instruction_in = '0;

   inst_cache dut (
      .clk                 (clk),
      .rst                 (rst),
      .rob_rollback_in     (rob_rollback_in),
      .fet_request_in      (fet_request_in),
      .fet_address_in      (fet_address_in),
      .fet_ready_out       (fet_ready_out),
      .fet_instruction_out (fet_instruction_out),
      .mc_request_out      (mc_request_out),
      .mc_address_out      (mc_address_out),
      .mc_ready_in         (mc_ready_in),
      .mc_instruction_in   (mc_instruction_in)
   );

   initial forever #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Backing memory contents: a fixed scramble of the word address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   // ---------------- memory controller responder (acts at edge+1) ----------------
   int          ready_count = 0;
   int          proto_err   = 0;
   int          fixed_delay = -1;
   logic [31:0] req_q[$];
   int          dly_q[$];
   bit          pending = 0;
   int          resp_dly = 0;
   logic [31:0] resp_addr = '0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         mc_ready_in = 1'b0;
         if (!rst) begin
            pending = 0;
         end else begin
            if (pending) begin
               if (resp_dly == 0) begin
                  mc_ready_in       = 1'b1;
                  mc_instruction_in = mem_word(resp_addr);
                  pending           = 0;
                  ready_count++;
               end else begin
                  resp_dly--;
               end
            end
            if (mc_request_out) begin
               if (pending) proto_err++;
               pending   = 1;
               resp_dly  = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 2));
               resp_addr = mc_address_out;
               req_q.push_back(mc_address_out);
               dly_q.push_back(resp_dly);
            end
         end
      end
   end

   // ---------------- line-level reference model ----------------
   bit          mv[32];
   logic [31:0] mt[32];

   function automatic int line_of(input logic [31:0] a);
      return int'((a / 16) % 32);
   endfunction

   function automatic bit model_hit(input logic [31:0] a);
      return mv[line_of(a)] && (mt[line_of(a)] == a / 512);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) mv[i] = 0;
   endtask

   // Main driver acts at edge+2, after the responder has settled.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic fetch_and_check(input logic [31:0] a, input bit exp_hit, input string nm);
      int          lat;
      int          exp_lat;
      bit          got;
      logic [31:0] instr;
      logic [31:0] wa;
      logic [31:0] base;
      wa   = a & ~32'h3;
      base = a & ~32'hF;
      req_q.delete();
      dly_q.delete();
      fet_address_in = a;
      fet_request_in = 1'b1;
      step();
      fet_request_in = 1'b0;
      got   = 0;
      lat   = 1;
      instr = '0;
      while (lat <= 60 && !got) begin
         if (fet_ready_out) begin
            got   = 1;
            instr = fet_instruction_out;
         end else begin
            step();
            lat++;
         end
      end
      check({nm, "_ready"}, 32'(got), 32'd1);
      check({nm, "_instr"}, instr, mem_word(wa));
      check({nm, "_nreq"}, req_q.size(), exp_hit ? 0 : 4);
      if (!exp_hit) begin
         for (int i = 0; i < 4 && i < req_q.size(); i++)
            check($sformatf("%s_req%0d", nm, i), req_q[i], base + 32'(4 * i));
      end
      exp_lat = 1;
      if (!exp_hit) foreach (dly_q[i]) exp_lat += dly_q[i] + 2;
      check({nm, "_lat"}, lat, exp_lat);
      step();
      check({nm, "_pulse1"}, 32'(fet_ready_out), 32'd0);
      mv[line_of(a)] = 1;
      mt[line_of(a)] = a / 512;
      $display("[TB] fetch %s addr=%08h hit=%0d lat=%0d instr=%08h", nm, a, exp_hit, lat, instr);
   endtask

   typedef struct {
      logic [31:0] addr;
      bit          exp_hit;
   } vec_t;

   vec_t vecs[10];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          base_rc;
      int          n;
      int          ready_seen;
      int          req_seen;
      logic [31:0] a;

      vecs[0] = '{32'h0000_1004, 1'b0};  // cold miss
      vecs[1] = '{32'h0000_1008, 1'b1};  // hit in freshly filled line
      vecs[2] = '{32'h0000_1000, 1'b1};
      vecs[3] = '{32'h0000_100C, 1'b1};
      vecs[4] = '{32'h0000_1200, 1'b0};  // same index, other tag: evict
      vecs[5] = '{32'h0000_1000, 1'b0};  // evicted line misses again
      vecs[6] = '{32'h0000_1204, 1'b0};
      vecs[7] = '{32'h0000_120B, 1'b1};  // byte bits ignored
      vecs[8] = '{32'h0000_1010, 1'b0};
      vecs[9] = '{32'h0000_1014, 1'b1};
      model_clear();

      // Reset state
      repeat (3) step();
      check("rst_fet_ready", 32'(fet_ready_out), 32'd0);
      check("rst_fet_instr", fet_instruction_out, 32'd0);
      check("rst_mc_req", 32'(mc_request_out), 32'd0);
      check("rst_mc_addr", mc_address_out, 32'd0);
      rst = 1'b1;
      step();

      // Directed table
      for (int i = 0; i < 10; i++)
         fetch_and_check(vecs[i].addr, vecs[i].exp_hit, $sformatf("vec%0d", i));

      // Rollback after the 2nd mc_ready_in of a 0x1000 fill
      fixed_delay = 2;
      req_q.delete();
      base_rc    = ready_count;
      ready_seen = 0;
      fet_address_in = 32'h0000_1000;
      fet_request_in = 1'b1;
      step();
      fet_request_in = 1'b0;
      n = 0;
      while (ready_count < base_rc + 2 && n < 100) begin
         if (fet_ready_out) ready_seen++;
         step();
         n++;
      end
      check("rb_two_readies", ready_count - base_rc, 2);
      step();
      rob_rollback_in = 1'b1;
      step();
      rob_rollback_in = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (fet_ready_out) ready_seen++;
         step();
      end
      check("rb_no_response", ready_seen, 0);
      check("rb_late_ready_sent", ready_count - base_rc, 3);
      check("rb_nreq", req_q.size(), 3);
      $display("[TB] rollback mid-fill requests=%0d readies=%0d", req_q.size(), ready_count - base_rc);
      mv[line_of(32'h1000)] = 0;
      fixed_delay = -1;
      fetch_and_check(32'h0000_1000, 1'b0, "rb_refetch");

      // Same-cycle rollback and fetch of a missing line
      req_q.delete();
      fet_address_in  = 32'h0000_3000;
      fet_request_in  = 1'b1;
      rob_rollback_in = 1'b1;
      step();
      fet_request_in  = 1'b0;
      rob_rollback_in = 1'b0;
      ready_seen = 0;
      req_seen   = 0;
      for (int i = 0; i < 5; i++) begin
         if (fet_ready_out) ready_seen++;
         if (mc_request_out) req_seen++;
         step();
      end
      check("rbreq_no_mc_req", req_seen + req_q.size(), 0);
      check("rbreq_no_response", ready_seen, 0);
      $display("[TB] rollback+fetch same cycle requests=%0d responses=%0d", req_seen, ready_seen);
      fetch_and_check(32'h0000_1008, 1'b1, "rbreq_idle_hit");

      // Asynchronous reset during a fill
      fet_address_in = 32'h0000_3000;
      fet_request_in = 1'b1;
      step();
      fet_request_in = 1'b0;
      check("ar_fill_started", 32'(mc_request_out), 32'd1);
      #3;
      rst = 1'b0;
      #1;
      check("ar_fet_ready", 32'(fet_ready_out), 32'd0);
      check("ar_fet_instr", fet_instruction_out, 32'd0);
      check("ar_mc_req", 32'(mc_request_out), 32'd0);
      check("ar_mc_addr", mc_address_out, 32'd0);
      $display("[TB] async reset mid-fill outputs=%0d/%08h/%0d/%08h",
               fet_ready_out, fet_instruction_out, mc_request_out, mc_address_out);
      step();
      rst = 1'b1;
      model_clear();
      repeat (2) step();
      fetch_and_check(32'h0000_1000, 1'b0, "ar_refetch");

      // Random fetches over a small set of lines and tags
      for (int i = 0; i < 120; i++) begin
         a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 4)
           | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3)
           | ($urandom_range(0, 1) << 31);
         fetch_and_check(a, model_hit(a), $sformatf("rnd%0d", i));
      end

      check("mc_one_outstanding", proto_err, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
